// File: rtl/instruction_loader.sv
// Writer side of the byte-wide little-endian instruction memory: accepts 32-bit
// words on a valid/ready stream and emits them as four consecutive byte writes.
module instruction_loader #(
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [63:0]      base_addr,
  input  logic             word_valid,
  input  logic [31:0]      word_data,
  input  logic             word_last,
  output logic             word_ready,
  output logic             mem_we,
  output logic [63:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             overflow_err,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 1);

  state_t             state_r, state_s;
  logic [63:0]        ptr_r, ptr_s;
  logic [31:0]        data_r, data_s;
  logic               last_r, last_s;
  logic [1:0]         idx_r, idx_s;
  logic [CNT_W-1:0]   count_r, count_s;

  logic               word_ready_r, word_ready_s;
  logic               mem_we_r, mem_we_s;
  logic [63:0]        mem_addr_r, mem_addr_s;
  logic [7:0]         mem_wdata_r, mem_wdata_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               err_r, err_s;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    byte_sel = w[7:0];
      2'd1:    byte_sel = w[15:8];
      2'd2:    byte_sel = w[23:16];
      2'd3:    byte_sel = w[31:24];
      default: byte_sel = 8'd0;
    endcase
  endfunction

  // Next-state and datapath register update
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    data_s  = data_r;
    last_s  = last_r;
    idx_s   = idx_r;
    count_s = count_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          ptr_s   = base_addr & ~64'd3;
          count_s = '0;
          idx_s   = 2'd0;
          state_s = ST_ACCEPT;
        end else begin
          state_s = state_r;
        end
      end
      ST_ACCEPT: begin
        if (word_valid && word_ready_r) begin
          if (ptr_r + 64'd3 > LAST_ADDR) begin
            state_s = ST_ERROR;
          end else begin
            data_s  = word_data;
            last_s  = word_last;
            idx_s   = 2'd0;
            state_s = ST_WRITE;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_WRITE: begin
        if (idx_r == 2'd3) begin
          ptr_s   = ptr_r + 64'd4;
          count_s = count_r + CNT_W'(1);
          idx_s   = 2'd0;
          state_s = last_r ? ST_DONE : ST_ACCEPT;
        end else begin
          idx_s = idx_r + 2'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        ptr_s   = 64'd0;
        idx_s   = 2'd0;
      end
    endcase
  end

  // Output values decoded from the upcoming state so outputs come straight from flops
  always_comb begin
    word_ready_s = 1'b0;
    mem_we_s     = 1'b0;
    mem_addr_s   = 64'd0;
    mem_wdata_s  = 8'd0;
    busy_s       = 1'b0;
    done_s       = 1'b0;
    err_s        = 1'b0;
    case (state_s)
      ST_ACCEPT: begin
        word_ready_s = 1'b1;
        busy_s       = 1'b1;
      end
      ST_WRITE: begin
        mem_we_s    = 1'b1;
        busy_s      = 1'b1;
        mem_addr_s  = ptr_s + {62'd0, idx_s};
        mem_wdata_s = byte_sel(data_s, idx_s);
      end
      ST_DONE:  done_s = 1'b1;
      ST_ERROR: err_s  = 1'b1;
      ST_IDLE:  busy_s = 1'b0;
      default:  busy_s = 1'b0;
    endcase
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      ptr_r        <= 64'd0;
      data_r       <= 32'd0;
      last_r       <= 1'b0;
      idx_r        <= 2'd0;
      count_r      <= '0;
      word_ready_r <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 64'd0;
      mem_wdata_r  <= 8'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      ptr_r        <= ptr_s;
      data_r       <= data_s;
      last_r       <= last_s;
      idx_r        <= idx_s;
      count_r      <= count_s;
      word_ready_r <= word_ready_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      err_r        <= err_s;
    end
  end

  assign word_ready   = word_ready_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign overflow_err = err_r;
  assign word_count   = count_r;

endmodule
